// File: rtl/pem_pkg.sv
// ---------------------------------------------------------------------------
// pem_pkg
// Shared types and width helpers for partition_error_monitor.
//   pem_state_e : sweep controller states
//   cnt_w()     : width of the erroneous-vector counter (holds 2^IN_W)
//   pc_w()      : width of a popcount over an OUT_W-bit vector
//   hd_w()      : width of the Hamming-distance accumulator (holds OUT_W*2^IN_W)
// ---------------------------------------------------------------------------
package pem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } pem_state_e;

   function automatic int cnt_w(input int in_w);
      return in_w + 1;
   endfunction

   function automatic int pc_w(input int out_w);
      return $clog2(out_w + 1);
   endfunction

   // OUT_W*2^IN_W < 2^(IN_W + clog2(OUT_W+1)), so this never saturates
   function automatic int hd_w(input int in_w, input int out_w);
      return in_w + pc_w(out_w);
   endfunction

endpackage

// File: rtl/partition_error_monitor_if.sv
// ---------------------------------------------------------------------------
// partition_error_monitor_if
// Bus between the monitor and the two partition copies under test.
//   stim_o   : vector applied to both copies (driven by the monitor)
//   exact_i  : exact copy output
//   approx_i : approximate copy output
// master = monitor side, slave = partition harness side.
// ---------------------------------------------------------------------------
interface partition_error_monitor_if #(
   parameter int IN_W  = 7,
   parameter int OUT_W = 4
);
   logic [IN_W-1:0]  stim_o;
   logic [OUT_W-1:0] exact_i;
   logic [OUT_W-1:0] approx_i;

   modport master (output stim_o, input exact_i, input approx_i);
   modport slave  (input stim_o, output exact_i, output approx_i);
endinterface

// File: rtl/pem_popcount.sv
// ---------------------------------------------------------------------------
// pem_popcount
// Combinational Hamming weight of a W-bit vector.
//   vec_i : input vector
//   cnt_o : number of set bits in vec_i
// ---------------------------------------------------------------------------
module pem_popcount
   import pem_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0]        vec_i,
   output logic [pc_w(W)-1:0]  cnt_o
);
   localparam int CW = pc_w(W);

   // sum the individual bits
   always_comb begin
      cnt_o = '0;
      for (int i = 0; i < W; i++) begin
         cnt_o = cnt_o + CW'(vec_i[i]);
      end
   end
endmodule

// File: rtl/partition_error_monitor.sv
// ---------------------------------------------------------------------------
// partition_error_monitor
// Exhaustively sweeps 2^IN_W input vectors into an exact and an approximate
// copy of a circuit partition and accumulates error metrics between them.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : pulse, starts a sweep from IDLE or DONE
//   part        : stimulus out / exact and approximate outputs in
//   busy        : sweep in progress (RUN or DRAIN)
//   done        : results valid, held until the next start
//   err_vec_cnt : vectors where exact and approximate outputs differ
//   hd_sum      : total Hamming distance over the sweep
//   max_abs_err : largest |exact - approx| (unsigned operands)
// ---------------------------------------------------------------------------
module partition_error_monitor
   import pem_pkg::*;
#(
   parameter int IN_W  = 7,
   parameter int OUT_W = 4,
   parameter int LAT   = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   partition_error_monitor_if.master    part,
   output logic                         busy,
   output logic                         done,
   output logic [cnt_w(IN_W)-1:0]       err_vec_cnt,
   output logic [hd_w(IN_W, OUT_W)-1:0] hd_sum,
   output logic [OUT_W-1:0]             max_abs_err
);
   localparam int CNT_W = cnt_w(IN_W);
   localparam int PC_W  = pc_w(OUT_W);
   localparam int HD_W  = hd_w(IN_W, OUT_W);
   localparam int DRN_W = (LAT > 0) ? $clog2(LAT + 1) : 1;
   localparam logic [IN_W-1:0] STIM_LAST = '1;

   pem_state_e        state_q, state_d;
   logic [IN_W-1:0]   stim_q, stim_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  err_q, err_d;
   logic [HD_W-1:0]   hd_q, hd_d;
   logic [OUT_W-1:0]  max_q, max_d;
   logic [DRN_W-1:0]  drain_q, drain_d;

   logic              run_s;
   logic              valid_s;
   logic [OUT_W-1:0]  xor_s;
   logic [PC_W-1:0]   pc_s;
   logic [OUT_W:0]    diff_s;
   logic [OUT_W:0]    abs_s;

   assign run_s = (state_q == RUN);

   // valid flag follows each vector through the partition latency
   if (LAT == 0) begin : g_no_lat
      assign valid_s = run_s;
   end else begin : g_lat
      logic [LAT-1:0] vld_q, vld_d;

      // shift the run flag in at bit 0
      always_comb begin
         vld_d = (vld_q << 1'b1) | LAT'(run_s);
      end

      // valid delay line register
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= '0;
         end else begin
            vld_q <= vld_d;
         end
      end

      assign valid_s = vld_q[LAT-1];
   end

   assign xor_s = part.exact_i ^ part.approx_i;

   pem_popcount #(.W(OUT_W)) u_popcount (
      .vec_i (xor_s),
      .cnt_o (pc_s)
   );

   // |exact - approx| at OUT_W+1 bits; the magnitude always fits in OUT_W
   always_comb begin
      diff_s = {1'b0, part.exact_i} - {1'b0, part.approx_i};
      if (diff_s[OUT_W]) begin
         abs_s = (~diff_s) + {{OUT_W{1'b0}}, 1'b1};
      end else begin
         abs_s = diff_s;
      end
   end

   // next-state, stimulus and accumulator update
   always_comb begin
      state_d = state_q;
      stim_d  = stim_q;
      drain_d = drain_q;
      err_d   = err_q;
      hd_d    = hd_q;
      max_d   = max_q;

      if (valid_s) begin
         err_d = err_q + CNT_W'(xor_s != '0);
         hd_d  = hd_q + HD_W'(pc_s);
         if (abs_s > {1'b0, max_q}) begin
            max_d = abs_s[OUT_W-1:0];
         end else begin
            max_d = max_q;
         end
      end else begin
         err_d = err_q;
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               stim_d  = '0;
               err_d   = '0;
               hd_d    = '0;
               max_d   = '0;
            end else begin
               state_d = state_q;
            end
         end
         RUN: begin
            // wraps to 0 after the last vector and is held there
            stim_d = stim_q + {{(IN_W-1){1'b0}}, 1'b1};
            if (stim_q == STIM_LAST) begin
               state_d = DRAIN;
               drain_d = '0;
            end else begin
               state_d = RUN;
            end
         end
         DRAIN: begin
            // LAT+1 cycles lets the last vector pass the partition and compare
            if (drain_q == DRN_W'(LAT)) begin
               state_d = DONE;
            end else begin
               drain_d = drain_q + {{(DRN_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == RUN) || (state_d == DRAIN);
      done_d = (state_d == DONE);
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         stim_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= '0;
         hd_q    <= '0;
         max_q   <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         stim_q  <= stim_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         hd_q    <= hd_d;
         max_q   <= max_d;
         drain_q <= drain_d;
      end
   end

   assign part.stim_o = stim_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err_vec_cnt = err_q;
   assign hd_sum      = hd_q;
   assign max_abs_err = max_q;
endmodule

// File: doc/partition_error_monitor.md
Name: partition_error_monitor

Overview:
- Upstream/downstream harness stage for one circuit partition (e.g. 7-in/4-out adder slice).
- Sweeps all 2^IN_W input vectors into an exact and an approximate copy of the partition, and compares their outputs every cycle.
- Accumulates error metrics used to score approximations: erroneous-vector count, total Hamming distance and max absolute error.
- Hardware replacement for printing exhaustive truth tables and diffing them offline.

Parameters:
- IN_W, 7: partition input width; the sweep covers 2^IN_W vectors.
- OUT_W, 4: partition output width.
- LAT, 0: pipeline latency of the partition copies in cycles (0 = combinational); both copies have equal latency.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a sweep when in IDLE or DONE.
- stim_o  out  IN_W  vector driven to both partition copies.
- exact_i  in  OUT_W  exact partition output.
- approx_i  in  OUT_W  approximate partition output.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE; results valid.
- err_vec_cnt  out  IN_W+1  number of vectors with exact_i != approx_i.
- hd_sum  out  IN_W+$clog2(OUT_W+1)  sum of popcount(exact_i ^ approx_i) over the sweep.
- max_abs_err  out  OUT_W  max |exact_i - approx_i|, both read as unsigned.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, stim_o=0, busy=0, done=0, all accumulators=0, valid delay line cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start: clear accumulators, set stim_o=0, go to RUN. done drops on the next cycle. Results stay held in DONE until start.
- RUN:
  - stim_o increments by 1 each cycle.
  - When stim_o = 2^IN_W-1, the next state is DRAIN.
  - stim_o then wraps to 0 and holds there.
- Valid delay line: a LAT-deep shift register carries a vector-valid flag (1 during RUN), so comparison happens on the cycle the partition output for that vector arrives. With LAT=0, comparison is in the same cycle as stim_o.
- Compare stage is registered, adding 1 cycle. On each valid cycle:
  - err_vec_cnt += (exact_i != approx_i)
  - hd_sum += popcount(exact_i ^ approx_i)
  - max_abs_err = max(max_abs_err, |exact_i - approx_i|)
- DRAIN: lasts LAT+1 cycles, until the last valid compare retires. Then go to DONE.
- Latency: done rises exactly 2^IN_W+LAT+1 cycles after the cycle start is sampled (129 at defaults).
- Width rules:
  - Accumulators are sized so they never saturate: max err_vec_cnt=2^IN_W, max hd_sum=OUT_W*2^IN_W.
  - |diff| is computed at OUT_W+1 bits before truncation; the truncation is lossless.
- start while busy: ignored, no restart, no effect on counters.
- start in the same cycle as reset deassertion: ignored; reset dominates.
- Reset mid-sweep: immediate return to IDLE with all outputs at reset values; a partial sweep is never reported as done.

Decomposition:
- Shared package pem_pkg:
  - FSM state enum {IDLE, RUN, DRAIN, DONE}.
  - Width helper functions for the counter/accumulator widths from IN_W/OUT_W.
- One natural sub-module: pem_popcount, parameterised W, combinational Hamming weight of the XOR vector.

Test Plan:
- Defaults, approx_i tied to exact_i, exact_i=stim_o[3:0], start pulse -> done at cycle 129; err_vec_cnt=0, hd_sum=0, max_abs_err=0; stim_o visits 0..127 once each.
- approx_i = exact_i ^ 4'b0001 -> err_vec_cnt=128, hd_sum=128, max_abs_err=1.
- exact_i=stim_o[3:0], approx_i=0 -> err_vec_cnt=120, hd_sum=256, max_abs_err=15.
- LAT=2 with a 2-stage registered model on both copies, approx=exact ^ 4'b1000 -> done at cycle 131; err_vec_cnt=128, hd_sum=128, max_abs_err=8; no off-by-one in the first or last vector.
- start re-pulsed at cycle 50 of a sweep -> ignored; same results and done timing as an undisturbed run.
- rst_n low at cycle 60, then start -> all outputs 0 while reset; the fresh sweep gives results identical to the matching clean run.
